// File: rtl/qdma_sched.sv
// Two-channel QBUS DMA scheduler: round-robin, one word per bus tenure, per-word and end-of-transfer pulses.
// Request appears one cycle after a channel is busy; the bus master's tenure (bus_master/dma_complete/nxm) paces all progress.
module qdma_sched (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  ch_start,
  input  logic [1:0]  ch_write,
  input  logic [43:0] ch_addr,
  input  logic [31:0] ch_count,
  output logic [1:0]  ch_busy,
  output logic [1:0]  ch_word,
  output logic [1:0]  ch_done,
  output logic [1:0]  ch_err,
  output logic        owner,
  output logic        dma_read,
  output logic        dma_write,
  output logic [21:0] dma_addr,
  input  logic        bus_master,
  input  logic        dma_complete,
  input  logic        nxm
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_CYCLE, S_END} state_t;

  state_t      state, state_nxt;
  logic [21:0] addr_q [2];
  logic [16:0] rem_q  [2];   // 17 bits so a loaded count of 0 represents 65536 words
  logic [1:0]  dir_q;
  logic [1:0]  err_q;
  logic        last_q;
  logic        nxm_seen;
  logic        pick;
  logic        word_ok;
  logic        finished;
  logic [1:0]  start_ok;

  always_comb begin
    pick = ch_busy[1];
    if (ch_busy == 2'b11)
      pick = ~last_q;
  end

  // A start coinciding with that channel's done pulse is dropped
  assign start_ok = ch_start & ~ch_busy & ~ch_done;
  assign word_ok  = (state == S_CYCLE) && dma_complete && !nxm && !nxm_seen;
  assign finished = (rem_q[owner] == 17'd0) || err_q[owner];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|ch_busy)   state_nxt = S_REQ;
      S_REQ:   if (bus_master) state_nxt = S_CYCLE;
      S_CYCLE: if (!bus_master) state_nxt = S_END;
      S_END:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch_busy   <= '0;
      ch_word   <= '0;
      ch_done   <= '0;
      ch_err    <= '0;
      owner     <= 1'b0;
      dma_read  <= 1'b0;
      dma_write <= 1'b0;
      dma_addr  <= '0;
      dir_q     <= '0;
      err_q     <= '0;
      last_q    <= 1'b1;
      nxm_seen  <= 1'b0;
      for (int n = 0; n < 2; n++) begin
        addr_q[n] <= '0;
        rem_q[n]  <= '0;
      end
    end else begin
      ch_word <= '0;
      ch_done <= '0;
      ch_err  <= '0;

      for (int n = 0; n < 2; n++) begin
        if (start_ok[n]) begin
          ch_busy[n] <= 1'b1;
          dir_q[n]   <= ch_write[n];
          err_q[n]   <= 1'b0;
          addr_q[n]  <= ch_addr[n*22 +: 22] & ~22'd1;
          rem_q[n]   <= (ch_count[n*16 +: 16] == 16'd0) ? 17'h10000
                                                          : {1'b0, ch_count[n*16 +: 16]};
        end
      end

      case (state)
        S_IDLE: begin
          if (|ch_busy) begin
            owner     <= pick;
            last_q    <= pick;
            dma_addr  <= addr_q[pick];
            dma_read  <= ~dir_q[pick];
            dma_write <= dir_q[pick];
            nxm_seen  <= 1'b0;
          end
        end
        S_CYCLE: begin
          if (nxm) begin
            err_q[owner] <= 1'b1;
            nxm_seen     <= 1'b1;
            dma_read     <= 1'b0;
            dma_write    <= 1'b0;
          end
          if (word_ok) begin
            ch_word       <= 2'b01 << owner;
            addr_q[owner] <= addr_q[owner] + 22'd2;
            rem_q[owner]  <= rem_q[owner] - 17'd1;
            if (rem_q[owner] == 17'd1) begin
              dma_read  <= 1'b0;
              dma_write <= 1'b0;
            end
          end
          if (!bus_master) begin
            dma_read  <= 1'b0;
            dma_write <= 1'b0;
          end
        end
        S_END: begin
          if (finished) begin
            ch_done        <= 2'b01 << owner;
            ch_err         <= {1'b0, err_q[owner]} << owner;
            ch_busy[owner] <= 1'b0;
            err_q[owner]   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
